// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced level into press/release/long/repeat strobes.
// Ports: clk, rst_n (sync, active-low), btn_level in; four strobes, held, event_count out.
module button_event_decoder #(
    parameter int CNT_W         = 26,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] event_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, release_n, long_n, repeat_n, held_n;
    logic [7:0]       count_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        count_n   = event_count;
        unique case (state)
            IDLE: begin
                if (btn_level) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    press_n = 1'b1;
                    count_n = event_count + 8'd1;
                end
            end
            PRESSED: begin
                // release is tested first so it wins over the terminal count
                if (!btn_level) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_n = LONG_HELD;
                    cnt_n   = '0;
                    long_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_level) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else if (cnt == REP_LAST) begin
                    cnt_n    = '0;
                    repeat_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        held_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            event_count   <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            repeat_pulse  <= repeat_n;
            held          <= held_n;
            event_count   <= count_n;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder (LONG_CYCLES=8, REPEAT_CYCLES=4).
// Table vectors plus hand-written long-press, reset and wrap sequences.
module tb_button_event_decoder;

    localparam int LC = 8;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_level = 1'b0;
    logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] event_count;

    int tests = 0;
    int failed = 0;

    button_event_decoder #(
        .CNT_W(26), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
        .held(held), .event_count(event_count)
    );

    always #5 clk = ~clk;

    // {press, release, long, repeat, held, event_count}
    function automatic logic [12:0] pk(input logic p, input logic r,
                                       input logic l, input logic rp,
                                       input logic h, input logic [7:0] c);
        return {p, r, l, rp, h, c};
    endfunction

    typedef struct {
        logic        rst;
        logic        btn;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[13];

    // Apply current inputs over one rising edge, then compare outputs.
    task automatic tick(input string nm, input logic [12:0] exp);
        logic [12:0] act;
        @(posedge clk);
        #1;
        act = {press_pulse, release_pulse, long_pulse, repeat_pulse,
               held, event_count};
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got p%b r%b l%b rp%b h%b cnt%0d, want p%b r%b l%b rp%b h%b cnt%0d",
                     nm, act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
        tests++;
        if (!$onehot0({press_pulse, release_pulse, long_pulse, repeat_pulse})) begin
            failed++;
            $display("FAIL onehot %s: strobes %b, want at most one high", nm,
                     {press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
    endtask

    // Press at relative edge 0, held through edge n-1, released at edge n.
    task automatic press_hold(input string nm, input int n, input logic [7:0] c);
        logic p, r, l, rp, h;
        for (int e = 0; e <= n + 1; e++) begin
            btn_level = (e < n);
            p  = (e == 0);
            r  = (e == n);
            l  = (e == LC) && (e < n);
            rp = (e >= LC + RC) && (e < n) && (((e - LC - RC) % RC) == 0);
            h  = (e < n);
            tick($sformatf("%s_e%0d", nm, e), pk(p, r, l, rp, h, c));
        end
    endtask

    initial begin
        // reset, reset override, one-cycle press, 5-edge short press
        tbl[0]  = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 8'd0)};
        tbl[1]  = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 8'd0)};
        tbl[2]  = '{1'b1, 1'b0, pk(0, 0, 0, 0, 0, 8'd0)};
        tbl[3]  = '{1'b1, 1'b1, pk(1, 0, 0, 0, 1, 8'd1)};
        tbl[4]  = '{1'b1, 1'b0, pk(0, 1, 0, 0, 0, 8'd1)};
        tbl[5]  = '{1'b1, 1'b0, pk(0, 0, 0, 0, 0, 8'd1)};
        tbl[6]  = '{1'b1, 1'b1, pk(1, 0, 0, 0, 1, 8'd2)};
        tbl[7]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1, 8'd2)};
        tbl[8]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1, 8'd2)};
        tbl[9]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1, 8'd2)};
        tbl[10] = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1, 8'd2)};
        tbl[11] = '{1'b1, 1'b0, pk(0, 1, 0, 0, 0, 8'd2)};
        tbl[12] = '{1'b1, 1'b0, pk(0, 0, 0, 0, 0, 8'd2)};

        for (int i = 0; i < 13; i++) begin
            rst_n     = tbl[i].rst;
            btn_level = tbl[i].btn;
            tick($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Long press: reset at edge 0, idle 1..9, held 10..39, low at 40.
        // press@10, long@18, repeat@22,26,30,34,38, release@40.
        rst_n = 1'b0;
        btn_level = 1'b0;
        tick("long_rst", pk(0, 0, 0, 0, 0, 8'd0));
        rst_n = 1'b1;
        for (int e = 1; e < 10; e++)
            tick($sformatf("long_idle%0d", e), pk(0, 0, 0, 0, 0, 8'd0));
        press_hold("long", 30, 8'd1);

        // Release exactly at the long terminal edge: release only.
        press_hold("rel_k8", LC, 8'd2);
        // Release exactly at the first repeat terminal edge: release only.
        press_hold("rel_rep", LC + RC, 8'd3);

        // Reset while in LONG_HELD, button kept pressed.
        btn_level = 1'b1;
        tick("rl_press", pk(1, 0, 0, 0, 1, 8'd4));
        for (int e = 1; e < LC; e++)
            tick($sformatf("rl_hold%0d", e), pk(0, 0, 0, 0, 1, 8'd4));
        tick("rl_long", pk(0, 0, 1, 0, 1, 8'd4));
        tick("rl_lh", pk(0, 0, 0, 0, 1, 8'd4));
        rst_n = 1'b0;
        tick("rl_reset", pk(0, 0, 0, 0, 0, 8'd0));
        rst_n = 1'b1;
        tick("rl_repress", pk(1, 0, 0, 0, 1, 8'd1));
        tick("rl_held", pk(0, 0, 0, 0, 1, 8'd1));
        btn_level = 1'b0;
        tick("rl_release", pk(0, 1, 0, 0, 0, 8'd1));

        // 256 short presses wrap event_count to 0, one more gives 1.
        rst_n = 1'b0;
        tick("wrap_rst", pk(0, 0, 0, 0, 0, 8'd0));
        rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] c;
            c = 8'((i + 1) % 256);
            btn_level = 1'b1;
            tick($sformatf("wrap_p%0d", i), pk(1, 0, 0, 0, 1, c));
            btn_level = 1'b0;
            tick($sformatf("wrap_r%0d", i), pk(0, 1, 0, 0, 0, c));
        end
        tick("wrap_end", pk(0, 0, 0, 0, 0, 8'd1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
